pwm_sfx_ctrl: RTL

PWM_SFX_CTRL -- requirements
Module: pwm_sfx_ctrl

---
 rtl/pwm_sfx_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_sfx_ctrl.sv
// pwm_sfx_ctrl: sound-effect sequencer that feeds a downstream pwmgen.
// It plays fixed (duty, ticks) step tables for three effects (die > eat > move),
// queues requests in per-effect pending bits, and lets die preempt the others.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   enable    sound on/off; low clears pending and ends any playing effect
//   req_die   death effect request (pulse or level)
//   req_eat   food-eaten effect request
//   req_move  move-click effect request
//   duty      duty value to pwmgen (R_SIZE+1 bits)
//   load      one-cycle strobe to pwmgen load
//   grant     one-hot {die,eat,move} of the effect playing, 0 when none
//   busy      high in every state except idle
module pwm_sfx_ctrl #(
    parameter int unsigned R_SIZE   = 8,
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            req_die,
    input  logic            req_eat,
    input  logic            req_move,
    output logic [R_SIZE:0] duty,
    output logic            load,
    output logic [2:0]      grant,
    output logic            busy
);
    localparam int unsigned   DW        = R_SIZE + 1;
    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [2:0] EffDie  = 3'b100;
    localparam logic [2:0] EffEat  = 3'b010;
    localparam logic [2:0] EffMove = 3'b001;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StEnd} state_e;

    // Step tables, indexed by the one-hot effect and the step number.
    function automatic logic [7:0] step_duty(input logic [2:0] eff, input logic [1:0] idx);
        logic [7:0] d;
        d = 8'd0;
        case (eff)
            EffMove: d = 8'd64;
            EffEat: begin
                case (idx)
                    2'd0:    d = 8'd96;
                    2'd1:    d = 8'd160;
                    default: d = 8'd224;
                endcase
            end
            EffDie: begin
                case (idx)
                    2'd0:    d = 8'd224;
                    2'd1:    d = 8'd160;
                    2'd2:    d = 8'd96;
                    default: d = 8'd32;
                endcase
            end
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] step_ticks(input logic [2:0] eff, input logic [1:0] idx);
        logic [3:0] t;
        t = 4'd2;
        case (eff)
            EffMove: t = 4'd2;
            EffEat:  t = (idx == 2'd2) ? 4'd3 : 4'd2;
            EffDie:  t = (idx == 2'd3) ? 4'd8 : 4'd4;
            default: t = 4'd2;
        endcase
        return t;
    endfunction

    function automatic logic step_last(input logic [2:0] eff, input logic [1:0] idx);
        logic l;
        l = 1'b1;
        case (eff)
            EffMove: l = 1'b1;
            EffEat:  l = (idx == 2'd2);
            EffDie:  l = (idx == 2'd3);
            default: l = 1'b1;
        endcase
        return l;
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    grant_q, grant_d;
    logic [1:0]    step_q, step_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ticks_q, ticks_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;
    logic [2:0]    win;
    logic          go_end;
    logic          play_done;
    logic [2:0]    req_vec;

    assign req_vec   = {req_die, req_eat, req_move};
    // Last cycle of the current step's PLAY window (ticks * TICK_DIV cycles).
    assign play_done = (presc_q == PRESC_MAX) &&
                       (ticks_q == step_ticks(grant_q, step_q) - 4'd1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        step_d  = step_q;
        presc_d = presc_q;
        ticks_d = ticks_q;
        duty_d  = duty_q;
        load_d  = 1'b0;
        win     = 3'b000;
        go_end  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    if (pend_q[2])      win = EffDie;
                    else if (pend_q[1]) win = EffEat;
                    else if (pend_q[0]) win = EffMove;
                end
            end
            StLoad, StPlay: begin
                if (!enable) begin
                    go_end = 1'b1;
                end else if (pend_q[2] && !grant_q[2]) begin
                    // Die preempts eat/move; the abandoned effect is dropped.
                    win = EffDie;
                end else if (state_q == StLoad) begin
                    state_d = StPlay;
                    presc_d = '0;
                    ticks_d = '0;
                end else if (!play_done) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        ticks_d = ticks_q + 4'd1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end else if (step_last(grant_q, step_q)) begin
                    go_end = 1'b1;
                end else begin
                    state_d = StLoad;
                    step_d  = step_q + 2'd1;
                    duty_d  = DW'(step_duty(grant_q, step_q + 2'd1));
                    load_d  = 1'b1;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (win != 3'b000) begin
            state_d = StLoad;
            grant_d = win;
            step_d  = 2'd0;
            duty_d  = DW'(step_duty(win, 2'd0));
            load_d  = 1'b1;
        end
        if (go_end) begin
            state_d = StEnd;
            grant_d = 3'b000;
            step_d  = 2'd0;
            duty_d  = '0;
            load_d  = 1'b1;
        end

        // A fresh request for the winner re-arms its bit, so it replays later.
        pend_d = enable ? ((pend_q & ~win) | req_vec) : 3'b000;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            grant_q <= '0;
            step_q  <= '0;
            presc_q <= '0;
            ticks_q <= '0;
            duty_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            step_q  <= step_d;
            presc_q <= presc_d;
            ticks_q <= ticks_d;
            duty_q  <= duty_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

    assign duty  = duty_q;
    assign load  = load_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule
